// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the 32-IMU SPI capture bridge.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LOAD,
    ST_SEND,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'hB0;
  localparam logic [7:0] CMD_SEND = 8'h90;
  localparam int         NUM_IMU  = 32;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [1:0] settle_q, settle_d;

  // Edges are masked until the whole chain holds real input, so a line that
  // is already low or high when reset releases never looks like an edge.
  always_comb begin
    sync_d   = {sync_q[0], din};
    prev_d   = sync_q[1];
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q   <= {2{RESET_VAL}};
      prev_q   <= RESET_VAL;
      settle_q <= 2'd0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
    end
  end

  assign rise = (settle_q == 2'd3) &  sync_q[1] & ~prev_q;
  assign fall = (settle_q == 2'd3) & ~sync_q[1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: LOAD captures 32 IMU lines per SCLK rise, SEND streams them back.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic clock,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  input  logic IMU_MISO1,  input  logic IMU_MISO2,  input  logic IMU_MISO3,  input  logic IMU_MISO4,
  input  logic IMU_MISO5,  input  logic IMU_MISO6,  input  logic IMU_MISO7,  input  logic IMU_MISO8,
  input  logic IMU_MISO9,  input  logic IMU_MISO10, input  logic IMU_MISO11, input  logic IMU_MISO12,
  input  logic IMU_MISO13, input  logic IMU_MISO14, input  logic IMU_MISO15, input  logic IMU_MISO16,
  input  logic IMU_MISO17, input  logic IMU_MISO18, input  logic IMU_MISO19, input  logic IMU_MISO20,
  input  logic IMU_MISO21, input  logic IMU_MISO22, input  logic IMU_MISO23, input  logic IMU_MISO24,
  input  logic IMU_MISO25, input  logic IMU_MISO26, input  logic IMU_MISO27, input  logic IMU_MISO28,
  input  logic IMU_MISO29, input  logic IMU_MISO30, input  logic IMU_MISO31, input  logic IMU_MISO32,
  output logic miso,
  output logic LED_CMD,
  output logic LED_LOAD,
  output logic LED_SEND
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = CW + 5;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [NUM_IMU-1:0] imu_raw, imu_s;
  logic [NUM_IMU:0]   data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic               mosi_s;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clock(clock), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clock(clock), .rst(rst), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  assign imu_raw = {IMU_MISO32, IMU_MISO31, IMU_MISO30, IMU_MISO29, IMU_MISO28, IMU_MISO27,
                    IMU_MISO26, IMU_MISO25, IMU_MISO24, IMU_MISO23, IMU_MISO22, IMU_MISO21,
                    IMU_MISO20, IMU_MISO19, IMU_MISO18, IMU_MISO17, IMU_MISO16, IMU_MISO15,
                    IMU_MISO14, IMU_MISO13, IMU_MISO12, IMU_MISO11, IMU_MISO10, IMU_MISO9,
                    IMU_MISO8,  IMU_MISO7,  IMU_MISO6,  IMU_MISO5,  IMU_MISO4,  IMU_MISO3,
                    IMU_MISO2,  IMU_MISO1};

  // Same two-stage depth as sclk, so each sample lines up with its SCLK edge.
  assign data_s1_d = {mosi, imu_raw};
  assign data_s2_d = data_s1_q;
  assign mosi_s    = data_s2_q[NUM_IMU];
  assign imu_s     = data_s2_q[NUM_IMU-1:0];

  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [6:0]         shift_q, shift_d;
  logic [CW-1:0]      count_q, count_d;
  logic [BW-1:0]      rd_bit_q, rd_bit_d;
  logic               miso_q, miso_d;
  logic               led_cmd_q, led_cmd_d, led_load_q, led_load_d, led_send_q, led_send_d;
  logic               wr_en;
  logic [7:0]         cmd_byte;
  logic [AW-1:0]      wr_addr, rd_addr;
  logic [NUM_IMU-1:0] rd_data_q;

  assign cmd_byte = {shift_q, mosi_s};
  assign wr_addr  = count_q[AW-1:0];
  assign rd_addr  = rd_bit_q[AW+4:5];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    count_d   = count_q;
    rd_bit_d  = rd_bit_q;
    miso_d    = miso_q;
    wr_en     = 1'b0;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
        ST_CMD: if (sclk_rise) begin
          shift_d   = cmd_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (cmd_byte == CMD_LOAD) begin
              state_d = ST_LOAD;
              count_d = '0;
            end else if (cmd_byte == CMD_SEND) begin
              state_d  = ST_SEND;
              rd_bit_d = '0;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_LOAD: if (sclk_rise && (count_q < DEPTH_C)) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
        end
        // The bit pointer saturates so an over-long readout keeps returning zeros.
        ST_SEND: if (sclk_fall) begin
          miso_d = (rd_bit_q[BW-1:5] < count_q) ? rd_data_q[rd_bit_q[4:0]] : 1'b0;
          if (rd_bit_q != '1) rd_bit_d = rd_bit_q + 1'b1;
        end
        default: ;
      endcase
    end
    if (state_d != ST_SEND) miso_d = 1'b0;
    led_cmd_d  = (state_d == ST_CMD);
    led_load_d = (state_d == ST_LOAD);
    led_send_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      count_q    <= '0;
      rd_bit_q   <= '0;
      miso_q     <= 1'b0;
      led_cmd_q  <= 1'b0;
      led_load_q <= 1'b0;
      led_send_q <= 1'b0;
    end else begin
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      rd_bit_q   <= rd_bit_d;
      miso_q     <= miso_d;
      led_cmd_q  <= led_cmd_d;
      led_load_q <= led_load_d;
      led_send_q <= led_send_d;
    end
  end

  // Capture buffer: one write port, one registered read port, contents not reset.
  logic [NUM_IMU-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= imu_s;
    rd_data_q <= mem[rd_addr];
  end

  assign miso     = miso_q;
  assign LED_CMD  = led_cmd_q;
  assign LED_LOAD = led_load_q;
  assign LED_SEND = led_send_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a buffer model predicts every miso bit of each SEND.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int DEPTH = 128;
  localparam int HALF  = 50;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic [31:0] imu_vec = '0;
  logic        miso, led_cmd, led_load, led_send;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_buf [DEPTH];
  int          model_count = 0;
  logic        exp_q [$];

  always #5 clock = ~clock;

  spi_slave #(.DEPTH(DEPTH)) dut (
    .clock(clock), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .IMU_MISO1(imu_vec[0]),   .IMU_MISO2(imu_vec[1]),   .IMU_MISO3(imu_vec[2]),   .IMU_MISO4(imu_vec[3]),
    .IMU_MISO5(imu_vec[4]),   .IMU_MISO6(imu_vec[5]),   .IMU_MISO7(imu_vec[6]),   .IMU_MISO8(imu_vec[7]),
    .IMU_MISO9(imu_vec[8]),   .IMU_MISO10(imu_vec[9]),  .IMU_MISO11(imu_vec[10]), .IMU_MISO12(imu_vec[11]),
    .IMU_MISO13(imu_vec[12]), .IMU_MISO14(imu_vec[13]), .IMU_MISO15(imu_vec[14]), .IMU_MISO16(imu_vec[15]),
    .IMU_MISO17(imu_vec[16]), .IMU_MISO18(imu_vec[17]), .IMU_MISO19(imu_vec[18]), .IMU_MISO20(imu_vec[19]),
    .IMU_MISO21(imu_vec[20]), .IMU_MISO22(imu_vec[21]), .IMU_MISO23(imu_vec[22]), .IMU_MISO24(imu_vec[23]),
    .IMU_MISO25(imu_vec[24]), .IMU_MISO26(imu_vec[25]), .IMU_MISO27(imu_vec[26]), .IMU_MISO28(imu_vec[27]),
    .IMU_MISO29(imu_vec[28]), .IMU_MISO30(imu_vec[29]), .IMU_MISO31(imu_vec[30]), .IMU_MISO32(imu_vec[31]),
    .miso(miso), .LED_CMD(led_cmd), .LED_LOAD(led_load), .LED_SEND(led_send)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives data during the SCLK low phase; the caller samples at its end.
  task automatic applyStimulus(input logic m, input logic [31:0] v);
    mosi    = m;
    imu_vec = v;
    #HALF;
  endtask

  task automatic sclk_high();
    sclk = 1'b1;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic start_txn();
    cs_n = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic end_txn();
    cs_n = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("idle_led_cmd", led_cmd, 0);
    checkOutput("idle_led_load", led_load, 0);
    checkOutput("idle_led_send", led_send, 0);
    checkOutput("idle_miso", miso, 0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      applyStimulus(b[7-i], $urandom);
      checkOutput("cmd_led_cmd", led_cmd, 1);
      checkOutput("cmd_led_load", led_load, 0);
      sclk_high();
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    send_bits(b, 8);
    if (b == CMD_LOAD) model_count = 0;
  endtask

  // mode 0: all lines follow 1,0,1,1,1,1,0,1; mode 1: random; mode 2: fixed word.
  task automatic load_phase(input int n, input int mode, input logic [31:0] fixed);
    logic        pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      if (mode == 0) v = pat[i % 8] ? 32'hFFFF_FFFF : 32'h0;
      else if (mode == 1) v = $urandom;
      else v = fixed;
      applyStimulus($urandom_range(0, 1), v);
      checkOutput("load_led_load", led_load, 1);
      checkOutput("load_led_cmd", led_cmd, 0);
      checkOutput("load_miso", miso, 0);
      sclk_high();
      if (model_count < DEPTH) begin
        model_buf[model_count] = v;
        model_count++;
      end
    end
  endtask

  task automatic send_phase(input int nbits);
    logic e;
    int   w;
    for (int k = 0; k < nbits; k++) begin
      w = k / 32;
      e = 1'b0;
      if (w < model_count) e = model_buf[w][k % 32];
      exp_q.push_back(e);
      applyStimulus($urandom_range(0, 1), $urandom);
      checkOutput("send_miso", miso, exp_q.pop_front());
      checkOutput("send_led_send", led_send, 1);
      sclk_high();
    end
  endtask

  task automatic do_send(input int nbits);
    start_txn();
    send_cmd(CMD_SEND);
    send_phase(nbits);
    end_txn();
  endtask

  initial begin
    #1500us;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      sclk = 1'($urandom); mosi = 1'($urandom); cs_n = 1'($urandom); imu_vec = $urandom;
      repeat (2) @(negedge clock);
      checkOutput("rst_miso", miso, 0);
      checkOutput("rst_led_cmd", led_cmd, 0);
      checkOutput("rst_led_load", led_load, 0);
      checkOutput("rst_led_send", led_send, 0);
    end
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    repeat (6) @(negedge clock);
    checkOutput("post_rst_led_cmd", led_cmd, 0);
    checkOutput("post_rst_miso", miso, 0);

    // LOAD of 16 toggling samples, then two repeated readouts
    start_txn();
    send_cmd(CMD_LOAD);
    load_phase(16, 0, 32'h0);
    end_txn();
    do_send(64);
    do_send(16 * 32 + 32);

    // Per-line bit ordering
    start_txn();
    send_cmd(CMD_LOAD);
    load_phase(1, 2, 32'h8000_0001);
    end_txn();
    do_send(40);

    // Unknown command leaves buffer and outputs alone
    start_txn();
    send_bits(8'h00, 8);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'($urandom), $urandom);
      checkOutput("ign_miso", miso, 0);
      checkOutput("ign_led_load", led_load, 0);
      checkOutput("ign_led_send", led_send, 0);
      sclk_high();
    end
    end_txn();
    do_send(40);

    // Command aborted after 5 bits, then a clean LOAD
    start_txn();
    send_bits(CMD_LOAD, 5);
    end_txn();
    start_txn();
    send_cmd(CMD_LOAD);
    load_phase(4, 1, 32'h0);
    end_txn();
    do_send(4 * 32 + 32);

    // Overfill: count saturates at DEPTH
    start_txn();
    send_cmd(CMD_LOAD);
    load_phase(DEPTH + 10, 1, 32'h0);
    end_txn();
    do_send(DEPTH * 32 + 32);

    // Reset in mid-LOAD, cs_n held low: no new command until a fresh falling edge
    start_txn();
    send_cmd(CMD_LOAD);
    load_phase(3, 1, 32'h0);
    rst = 1'b0;
    model_count = 0;
    repeat (2) @(negedge clock);
    checkOutput("midrst_led_load", led_load, 0);
    checkOutput("midrst_miso", miso, 0);
    rst = 1'b1;
    repeat (6) @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i < 8) ? CMD_LOAD[7-i] : 1'b1, $urandom);
      checkOutput("midrst_led_cmd", led_cmd, 0);
      checkOutput("midrst_led_load2", led_load, 0);
      sclk_high();
    end
    end_txn();
    do_send(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
